fp_mult_pipe: RTL and testbench
===============================

// Module: fp_mult_pipe
// PURPOSE
//  Parametrised, pipelined floating-point multiplier; generalises the fp8 multiplier to any
//  sign/EXP_W/MAN_W format, adds runtime rounding mode and valid/ready flow control.
//  Fixed 3-cycle latency, one result per cycle. Sits between operand-fetch and accumulate stages.
// PARAMETERS
//  EXP_W   3                    exponent field width (>=2)
//  MAN_W   4                    stored mantissa width (>=2); hidden leading 1 always implied
//  BIAS    2**(EXP_W-1)-1       exponent bias (3 for the default fp8 1-3-4 format)
//  W       1+EXP_W+MAN_W        total word width (derived, do not override)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   block accepts operands this cycle
//  a          in   W   operand A {sign, exp, man}
//  b          in   W   operand B
//  rm         in   2   rounding mode sampled with operands: 0 RNE, 1 RTZ, 2 RDN (-inf), 3 RUP (+inf)
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts result
//  result     out  W   product
//  flags      out  5   {NV, DZ, OF, UF, NX}; NV and DZ tied 0 (format has no Inf/NaN)
// BEHAVIOUR
//  Format: zero iff exp==0 && man==0 (either sign). Every other code is normal,
//   value = (-1)^s * 1.man * 2^(exp-BIAS), exp==0 included. No Inf/NaN/subnormals.
//  Pipeline: S1 decode, zero detect, sign xor, exponent sum; S2 (MAN_W+1)^2 product;
//   S3 normalise (shift by <=1), round per rm, range check, pack.
//  Flow: adv = ~s3_valid | out_ready; in_ready = adv; all stages shift together when adv.
//   Stall holds every stage incl. result/flags stable; no combinational path in_valid->out_valid.
//   Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  Latency: a pair accepted at edge N appears with out_valid=1 after edge N+3 (no stalls).
//  Rounding: guard/sticky from discarded product bits; RNE ties-to-even; RDN/RUP on sign.
//   Rounding carry out of mantissa renormalises (exp+1, man=0), then range check.
//  Zero: either operand zero -> result {s_a^s_b, 0...0}, flags 0.
//  Overflow: biased exp > 2^EXP_W-1 -> saturate to {s, all-ones exp, all-ones man}, OF|NX.
//  Underflow: biased exp < 0, or rounded result encodes exp==0 && man==0 -> signed zero, UF|NX.
//  NX set whenever any discarded bit is nonzero or OF/UF is set.
//  Reset (async, any cycle, incl. mid-pipeline): all stage valids 0 -> out_valid=0, result=0,
//   flags=0; in-flight operations are discarded, no partial output after release.
//  in_ready reset value 1 (pipe empty).
// TESTING (default fp8 1-3-4, BIAS 3)
//  1 a=8'h44 (2.5), b=8'h40 (2.0), rm=RNE -> result 8'h54 (5.0), flags 0, 3 cycles later
//  2 a=8'h41, b=8'h41 (2.125^2=4.515625): rm=RNE -> 8'h52 flags NX; rm=RUP -> 8'h53 NX;
//    rm=RTZ -> 8'h52 NX
//  3 a=8'h7F, b=8'h7F -> 8'h7F flags OF|NX; a=8'hFF, b=8'h7F -> 8'hFF OF|NX
//  4 a=8'h10, b=8'h10 (2^-4) -> 8'h00 flags UF|NX; a=8'h80, b=8'h44 -> 8'h80, flags 0
//  5 back-to-back stream of 20 random pairs, out_ready toggled randomly -> results in order,
//    held stable while out_ready=0, none lost or duplicated, match real-arithmetic model
//  6 assert rst_n low with 3 ops in flight -> out_valid drops immediately;
//    no stale result after release

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Pipelined sign/EXP_W/MAN_W floating-point multiplier with runtime rounding mode and
// valid/ready flow control; four register ranks give a fixed 3-cycle accept-to-output latency.
module fp_mult_pipe #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int BIAS  = 2**(EXP_W-1)-1,
  localparam int W    = 1+EXP_W+MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags
);

  localparam int EW = EXP_W+3;
  localparam int PW = 2*MAN_W+2;
  localparam logic signed [EW-1:0] EMAX = EW'((2**EXP_W)-1);

  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP} rm_e;

  logic                    w_adv;
  logic                    w_zero;
  logic signed [EW-1:0]    w_s1_exp;

  logic                    r_v1, r_s1_sign, r_s1_zero;
  logic signed [EW-1:0]    r_s1_exp;
  logic [MAN_W:0]          r_s1_ma, r_s1_mb;
  logic [1:0]              r_s1_rm;

  logic                    r_v2, r_s2_sign, r_s2_zero;
  logic signed [EW-1:0]    r_s2_exp;
  logic [PW-1:0]           r_s2_prod;
  logic [1:0]              r_s2_rm;

  logic                    w_hi, w_guard, w_sticky, w_inc;
  logic [MAN_W-1:0]        w_man_n;
  logic [MAN_W:0]          w_man_sum;
  logic signed [EW-1:0]    w_exp_n;

  logic                    r_v3, r_s3_sign, r_s3_zero, r_s3_inexact;
  logic signed [EW-1:0]    r_s3_exp;
  logic [MAN_W-1:0]        r_s3_man;

  logic                    w_of, w_uf;
  logic [W-1:0]            w_res;
  logic [4:0]              w_flags;

  logic                    r_out_valid;
  logic [W-1:0]            r_result;
  logic [4:0]              r_flags;

  assign w_adv     = ~r_out_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // Decode: only the all-zero exponent/mantissa code is zero, the hidden one is always present.
  assign w_zero   = (a[W-2:0] == '0) | (b[W-2:0] == '0);
  assign w_s1_exp = EW'(a[W-2 -: EXP_W]) + EW'(b[W-2 -: EXP_W]) - EW'(BIAS);

  // Normalise: the product of two [1,2) significands lies in [1,4), so at most one right shift.
  assign w_hi     = r_s2_prod[PW-1];
  assign w_man_n  = w_hi ? r_s2_prod[PW-2 -: MAN_W] : r_s2_prod[PW-3 -: MAN_W];
  assign w_guard  = w_hi ? r_s2_prod[MAN_W] : r_s2_prod[MAN_W-1];
  assign w_sticky = w_hi ? |r_s2_prod[MAN_W-1:0] : |r_s2_prod[MAN_W-2:0];
  assign w_exp_n  = r_s2_exp + EW'(w_hi);

  always_comb begin
    w_inc = 1'b0;
    case (rm_e'(r_s2_rm))
      RM_RNE:  w_inc = w_guard & (w_sticky | w_man_n[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = r_s2_sign & (w_guard | w_sticky);
      RM_RUP:  w_inc = ~r_s2_sign & (w_guard | w_sticky);
      default: w_inc = 1'b0;
    endcase
  end

  assign w_man_sum = {1'b0, w_man_n} + (MAN_W+1)'(w_inc);

  // Range check happens after rounding so a rounding carry can itself overflow.
  assign w_of = ~r_s3_zero & ~r_s3_exp[EW-1] & (r_s3_exp > EMAX);
  assign w_uf = ~r_s3_zero & (r_s3_exp[EW-1] | ((r_s3_exp == '0) & (r_s3_man == '0)));

  always_comb begin
    w_res = {r_s3_sign, r_s3_exp[EXP_W-1:0], r_s3_man};
    if (r_s3_zero | w_uf) begin
      w_res = {r_s3_sign, {(W-1){1'b0}}};
    end else if (w_of) begin
      w_res = {r_s3_sign, {(W-1){1'b1}}};
    end
    w_flags = {2'b00, w_of, w_uf, ~r_s3_zero & (r_s3_inexact | w_of | w_uf)};
  end

  // Every rank advances together, so a stall freezes the whole pipe including the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1         <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_zero    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_ma      <= '0;
      r_s1_mb      <= '0;
      r_s1_rm      <= '0;
      r_v2         <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_zero    <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_prod    <= '0;
      r_s2_rm      <= '0;
      r_v3         <= 1'b0;
      r_s3_sign    <= 1'b0;
      r_s3_zero    <= 1'b0;
      r_s3_inexact <= 1'b0;
      r_s3_exp     <= '0;
      r_s3_man     <= '0;
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_flags      <= '0;
    end else if (w_adv) begin
      r_v1         <= in_valid;
      r_s1_sign    <= a[W-1] ^ b[W-1];
      r_s1_zero    <= w_zero;
      r_s1_exp     <= w_s1_exp;
      r_s1_ma      <= {1'b1, a[MAN_W-1:0]};
      r_s1_mb      <= {1'b1, b[MAN_W-1:0]};
      r_s1_rm      <= rm;

      r_v2         <= r_v1;
      r_s2_sign    <= r_s1_sign;
      r_s2_zero    <= r_s1_zero;
      r_s2_exp     <= r_s1_exp;
      r_s2_prod    <= PW'(r_s1_ma) * PW'(r_s1_mb);
      r_s2_rm      <= r_s1_rm;

      r_v3         <= r_v2;
      r_s3_sign    <= r_s2_sign;
      r_s3_zero    <= r_s2_zero;
      r_s3_inexact <= w_guard | w_sticky;
      r_s3_exp     <= w_exp_n + EW'(w_man_sum[MAN_W]);
      r_s3_man     <= w_man_sum[MAN_W-1:0];

      r_out_valid  <= r_v3;
      r_result     <= w_res;
      r_flags      <= w_flags;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe (fp8 1-3-4): hand-computed vectors, a flow-controlled
// stream against a real-arithmetic model, and an asynchronous reset with operations in flight.
`timescale 1ns/1ps
module tb_fp_mult_pipe;

  logic       clk = 1'b0;
  logic       rstN;
  logic       inValid;
  logic       inReady;
  logic [7:0] opA;
  logic [7:0] opB;
  logic [1:0] rm;
  logic       outValid;
  logic       outReady;
  logic [7:0] result;
  logic [4:0] flags;

  int checks = 0;
  int errors = 0;

  logic [15:0] expQ[$];

  fp_mult_pipe dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .rm        (rm),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Real-valued reference: exact product, then rounding decided on the fractional remainder.
  function automatic logic [15:0] refMul(input logic [7:0] x, input logic [7:0] y, input logic [1:0] mode);
    logic sign;
    real  mag, scaled, frac;
    int   e, mi, be;
    logic inexact, up;
    sign = x[7] ^ y[7];
    if (x[6:0] == 7'd0 || y[6:0] == 7'd0) return {8'h00, sign, 7'h00};
    mag = real'((16 + int'(x[3:0])) * (16 + int'(y[3:0])));
    e   = int'(x[6:4]) + int'(y[6:4]) - 6 - 8;
    while (mag >= 2.0) begin
      mag = mag / 2.0;
      e++;
    end
    scaled  = mag * 16.0;
    mi      = $rtoi(scaled);
    frac    = scaled - real'(mi);
    inexact = (frac != 0.0);
    case (mode)
      2'd0:    up = (frac > 0.5) || (frac == 0.5 && (mi % 2) == 1);
      2'd2:    up = sign && inexact;
      2'd3:    up = !sign && inexact;
      default: up = 1'b0;
    endcase
    if (up) mi++;
    if (mi == 32) begin
      mi = 16;
      e++;
    end
    be = e + 3;
    if (be > 7) return {3'b000, 5'b00101, sign, 7'h7F};
    if (be < 0 || (be == 0 && mi == 16)) return {3'b000, 5'b00011, sign, 7'h00};
    return {3'b000, 4'b0000, inexact, sign, be[2:0], mi[3:0]};
  endfunction

  // Presents one operand pair across a single rising edge, called just after an edge.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [1:0] mode);
    inValid = 1'b1;
    opA     = x;
    opB     = y;
    rm      = mode;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic runOne(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [1:0] mode,
                        input logic [7:0] expRes, input logic [4:0] expFlags);
    outReady = 1'b1;
    checkOutput({tag, "_inready"}, 16'(inReady), 16'd1);
    applyStimulus(x, y, mode);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput({tag, "_early"}, 16'(outValid), 16'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, 16'(outValid), 16'd1);
    checkOutput({tag, "_data"}, {3'b000, flags, result}, {3'b000, expFlags, expRes});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  curA, curB;
    logic [1:0]  curRm;
    logic [15:0] holdVal;
    logic        holdPending;
    int          sent, got, cyc;

    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    opA      = 8'h00;
    opB      = 8'h00;
    rm       = 2'd0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_valid", 16'(outValid), 16'd0);
    checkOutput("rst_result", 16'(result), 16'd0);
    checkOutput("rst_flags", 16'(flags), 16'd0);
    checkOutput("rst_inready", 16'(inReady), 16'd1);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    runOne("t1_mul",    8'h44, 8'h40, 2'd0, 8'h54, 5'b00000);
    runOne("t2_rne",    8'h41, 8'h41, 2'd0, 8'h52, 5'b00001);
    runOne("t2_rup",    8'h41, 8'h41, 2'd3, 8'h53, 5'b00001);
    runOne("t2_rtz",    8'h41, 8'h41, 2'd1, 8'h52, 5'b00001);
    runOne("t2_neg_rdn",8'hC1, 8'h41, 2'd2, 8'hD3, 5'b00001);
    runOne("t2_neg_rup",8'hC1, 8'h41, 2'd3, 8'hD2, 5'b00001);
    runOne("t3_of_pos", 8'h7F, 8'h7F, 2'd0, 8'h7F, 5'b00101);
    runOne("t3_of_neg", 8'hFF, 8'h7F, 2'd0, 8'hFF, 5'b00101);
    runOne("t4_uf",     8'h10, 8'h10, 2'd0, 8'h00, 5'b00011);
    runOne("t4_zero",   8'h80, 8'h44, 2'd0, 8'h80, 5'b00000);
    runOne("rnd_carry", 8'h35, 8'h38, 2'd0, 8'h40, 5'b00001);
    runOne("rnd_trunc", 8'h35, 8'h38, 2'd1, 8'h3F, 5'b00001);
    runOne("uf_exp0",   8'h10, 8'h20, 2'd0, 8'h00, 5'b00011);
    runOne("exp0_norm", 8'h18, 8'h20, 2'd0, 8'h08, 5'b00000);

    $display("[TB] flow-controlled stream");
    sent        = 0;
    got         = 0;
    cyc         = 0;
    holdPending = 1'b0;
    holdVal     = 16'h0000;
    curA        = 8'($urandom_range(0, 255));
    curB        = 8'($urandom_range(0, 255));
    curRm       = 2'($urandom_range(0, 3));
    while ((sent < 20 || got < 20) && cyc < 400) begin
      inValid  = (sent < 20);
      opA      = curA;
      opB      = curB;
      rm       = curRm;
      outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (holdPending) checkOutput("stream_hold", {2'b00, outValid, flags, result}, holdVal);
      if (outValid && outReady) begin
        if (expQ.size() == 0) checkOutput("stream_extra", 16'(outValid), 16'd0);
        else checkOutput("stream_data", {3'b000, flags, result}, expQ.pop_front());
        got++;
      end
      holdPending = outValid && !outReady;
      holdVal     = {2'b00, outValid, flags, result};
      if (inValid && inReady) begin
        expQ.push_back(refMul(curA, curB, curRm));
        sent++;
        curA  = 8'($urandom_range(0, 255));
        curB  = 8'($urandom_range(0, 255));
        curRm = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    inValid = 1'b0;
    checkOutput("stream_count", 16'(got), 16'd20);
    checkOutput("stream_in_time", 16'(cyc < 400), 16'd1);

    $display("[TB] reset with operations in flight");
    outReady = 1'b0;
    applyStimulus(8'h44, 8'h40, 2'd0);
    applyStimulus(8'h41, 8'h41, 2'd0);
    applyStimulus(8'h7F, 8'h7F, 2'd0);
    @(posedge clk);
    #1;
    checkOutput("flight_valid", 16'(outValid), 16'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_valid", 16'(outValid), 16'd0);
    checkOutput("arst_result", 16'(result), 16'd0);
    checkOutput("arst_flags", 16'(flags), 16'd0);
    checkOutput("arst_inready", 16'(inReady), 16'd1);
    @(negedge clk);
    rstN     = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("arst_no_stale", 16'(outValid), 16'd0);
    end
    @(posedge clk);
    #1;
    runOne("post_rst", 8'h44, 8'h40, 2'd0, 8'h54, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
